// File: rtl/kf_pkg.sv
// kf_pkg: shared opcodes, micro-op field layout and sequencer state encoding
// for the Kalman filter bank sequencer.
package kf_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_MOVQ = 3'd4,
    OP_MOVD = 3'd5,
    OP_COPY = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Micro-op word layout: {op, dst, src_b, src_a}, src_a in the low bits.
  function automatic int unsigned uop_src_b_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned uop_dst_lsb(input int unsigned aw);
    return 2 * aw;
  endfunction

  function automatic int unsigned uop_op_lsb(input int unsigned aw);
    return 3 * aw;
  endfunction

endpackage

// File: rtl/kf_prog_table.sv
// kf_prog_table: micro-op program store, synchronous write, registered read.
// Contents are deliberately not reset.
module kf_prog_table #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 21
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/kf_bank_seq.sv
// kf_bank_seq: micro-op sequencer driving the data bank, RQ/RD and the ALU handshake.
// Define KF_BANK_SEQ_TIMEOUT_EN to abort stalled ALU transactions after TIMEOUT cycles.
module kf_bank_seq
  import kf_pkg::*;
#(
  parameter int unsigned W          = 24,
  parameter int unsigned DB_DEPTH   = 40,
  parameter int unsigned ADDRW      = 6,
  parameter int unsigned PROG_DEPTH = 32,
  parameter int unsigned PCW        = 5
`ifdef KF_BANK_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_we,
  input  logic [PCW-1:0]         prog_addr,
  input  logic [3+3*ADDRW-1:0]   prog_wdata,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDRW-1:0]       db_raddr_a,
  output logic [ADDRW-1:0]       db_raddr_b,
  input  logic [W-1:0]           db_rdata_a,
  input  logic [W-1:0]           db_rdata_b,
  output logic                   db_we,
  output logic [ADDRW-1:0]       db_waddr,
  output logic [W-1:0]           db_wdata,
  output logic                   rq_we,
  output logic                   rd_we,
  output logic [W-1:0]           rq_d,
  output logic [W-1:0]           rd_d,
  output logic                   alu_req_valid,
  input  logic                   alu_req_ready,
  output logic [1:0]             alu_op,
  input  logic                   alu_rsp_valid,
  input  logic [W-1:0]           alu_rsp_data
);

  localparam int unsigned IW        = OP_W + 3*ADDRW;
  localparam int unsigned SRC_B_LSB = uop_src_b_lsb(ADDRW);
  localparam int unsigned DST_LSB   = uop_dst_lsb(ADDRW);
  localparam int unsigned OP_LSB    = uop_op_lsb(ADDRW);
  localparam int unsigned AW1       = ADDRW + 1;
  localparam logic [AW1-1:0] DB_LIM  = AW1'(DB_DEPTH);
  localparam logic [PCW-1:0] PC_LAST = PCW'(PROG_DEPTH - 1);

  state_e           state, state_nxt;
  logic [PCW-1:0]   pc;
  logic [IW-1:0]    ir;
  logic [W-1:0]     res;
  logic             err_set;
  logic             tmo_hit;
  logic [ADDRW-1:0] src_a, src_b, dst;
  op_e              op;
  logic             op_alu;
  logic             addr_bad;
  logic             unused_rdata_b;

  // Operand B is consumed by the ALU straight from the bank port.
  assign unused_rdata_b = ^db_rdata_b;

  assign src_a  = ir[0 +: ADDRW];
  assign src_b  = ir[SRC_B_LSB +: ADDRW];
  assign dst    = ir[DST_LSB +: ADDRW];
  assign op     = op_e'(ir[OP_LSB +: OP_W]);
  assign op_alu = ~ir[OP_LSB + 2];

  assign addr_bad = ({1'b0, src_a} >= DB_LIM)
                 || (op_alu && ({1'b0, src_b} >= DB_LIM))
                 || ((op_alu || op == OP_COPY) && ({1'b0, dst} >= DB_LIM));

  kf_prog_table #(
    .DEPTH(PROG_DEPTH),
    .AW   (PCW),
    .DW   (IW)
  ) u_prog (
    .clk  (clk),
    .we   (prog_we && !busy),
    .waddr(prog_addr),
    .wdata(prog_wdata),
    .re   (state == ST_FETCH),
    .raddr(pc),
    .rdata(ir)
  );

`ifdef KF_BANK_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] tmo_cnt;

  // Any state change restarts the count, so it is zero on entry to ISSUE and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       tmo_cnt <= '0;
    else if (state_nxt != state)                      tmo_cnt <= '0;
    else if (state == ST_ISSUE || state == ST_WAIT)   tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_HALT) begin
          state_nxt = ST_DONE;
        end else if (addr_bad) begin
          err_set   = 1'b1;
          state_nxt = ST_DONE;
        end else if (op_alu) begin
          state_nxt = ST_ISSUE;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC:   state_nxt = ST_NEXT;
      ST_ISSUE: begin
        if (alu_req_ready) begin
          state_nxt = ST_WAIT;
        end else if (tmo_hit) begin
          err_set   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (alu_rsp_valid) begin
          state_nxt = ST_WRITE;
        end else if (tmo_hit) begin
          err_set   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_WRITE:  state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (pc == PC_LAST) begin
          err_set   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (prog_we && busy) err_set = 1'b1;
    if (alu_rsp_valid && state != ST_WAIT) err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      err   <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) pc <= '0;
      else if (state == ST_NEXT && state_nxt == ST_FETCH) pc <= pc + 1'b1;
      if (err_set) err <= 1'b1;
      else if (state == ST_IDLE && start) err <= 1'b0;
      if (state == ST_WAIT && alu_rsp_valid) res <= alu_rsp_data;
    end
  end

  always_comb begin
    busy          = (state != ST_IDLE) && (state != ST_DONE);
    done          = (state == ST_DONE);
    db_raddr_a    = '0;
    db_raddr_b    = '0;
    db_we         = 1'b0;
    db_waddr      = '0;
    db_wdata      = '0;
    rq_we         = 1'b0;
    rd_we         = 1'b0;
    rq_d          = '0;
    rd_d          = '0;
    alu_req_valid = 1'b0;
    alu_op        = '0;
    case (state)
      ST_EXEC: begin
        db_raddr_a = src_a;
        case (op)
          OP_MOVQ: begin rq_we = 1'b1; rq_d = db_rdata_a; end
          OP_MOVD: begin rd_we = 1'b1; rd_d = db_rdata_a; end
          OP_COPY: begin db_we = 1'b1; db_waddr = dst; db_wdata = db_rdata_a; end
          default: ;
        endcase
      end
      ST_ISSUE: begin
        db_raddr_a    = src_a;
        db_raddr_b    = src_b;
        alu_req_valid = 1'b1;
        alu_op        = ir[OP_LSB +: 2];
      end
      ST_WRITE: begin
        db_we    = 1'b1;
        db_waddr = dst;
        db_wdata = res;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/kf_bank_seq.md
Name: kf_bank_seq

Overview:
- Micro-op sequencer that drives the data bank (2 async read ports, 1 sync write port) and the RQ/RD registers of the Kalman filter datapath.
- Executes a host-loaded program of register-transfer and ALU micro-ops: reads operands, hands them to the external arithmetic unit via valid/ready, and writes results back.
- Sits between the host/config interface and the mem_reg + ALU datapath.

Parameters:
- W, 24, datapath word width
- DB_DEPTH, 40, number of data bank entries
- ADDRW, 6, data bank address width
- PROG_DEPTH, 32, micro-op table entries (power of 2)
- PCW, 5, program counter width, log2(PROG_DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- prog_we  in  1  program table write strobe
- prog_addr  in  PCW  program table write address
- prog_wdata  in  3+3*ADDRW  micro-op {op[2:0], dst, src_b, src_a}
- start  in  1  start pulse; execution begins at pc=0
- busy  out  1  program running
- done  out  1  one-cycle pulse on HALT or abort
- err  out  1  sticky error; cleared by next accepted start
- db_raddr_a / db_raddr_b  out  ADDRW  bank read addresses
- db_rdata_a / db_rdata_b  in  W  bank read data (async)
- db_we  out  1  bank write enable
- db_waddr  out  ADDRW  bank write address
- db_wdata  out  W  bank write data
- rq_we / rd_we  out  1  RQ / RD write enables
- rq_d / rd_d  out  W  RQ / RD write data
- alu_req_valid  out  1  operands + op valid
- alu_req_ready  in  1  ALU accepts
- alu_op  out  2  0 ADD, 1 SUB, 2 MUL, 3 DIV
- alu_rsp_valid  in  1  result valid, single-cycle pulse
- alu_rsp_data  in  W  result

Behaviour:
- Opcodes: 0–3 ALU ops; 4 MOVQ (RQ<=db[src_a]); 5 MOVD (RD<=db[src_a]); 6 COPY (db[dst]<=db[src_a]); 7 HALT.
- Reset: state IDLE, pc=0, every output 0. Program table is not reset.
- prog_we is honoured only when busy=0. prog_we while busy: write dropped, err set.
- States:
  - IDLE: start -> FETCH, busy=1, err cleared, pc=0.
  - FETCH (1 cycle): ir <= table[pc].
  - DECODE: HALT -> DONE. Any used address (src_a, src_b for ALU ops; dst for ALU/COPY) >= DB_DEPTH -> err=1, DONE. ALU op -> ISSUE. Other ops -> EXEC.
  - EXEC (1 cycle): raddr_a=src_a. Strobes the matching rq_we, rd_we, or db_we with data=db_rdata_a (db_waddr=dst for COPY). Then -> NEXT.
  - ISSUE: raddr_a/b = src_a/b held stable; alu_req_valid=1, alu_op=op[1:0]. Stay until alu_req_ready. The ALU captures operands in the handshake cycle. Then -> WAIT.
  - WAIT: alu_rsp_valid -> res<=alu_rsp_data -> WRITE.
  - WRITE (1 cycle): db_we=1, db_waddr=dst, db_wdata=res -> NEXT.
  - NEXT: if pc==PROG_DEPTH-1, err=1 -> DONE (run-off without HALT); else pc+1 -> FETCH.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency:
  - Non-ALU op: 4 cycles (FETCH, DECODE, EXEC, NEXT).
  - ALU op: 5 cycles + ready wait + response wait.
- start while busy: ignored, no error.
- alu_rsp_valid outside WAIT: ignored, err set.
- Reset mid-program: immediate return to IDLE; no write strobe is asserted after reset.
- All write-enable outputs are combinational from state, at most one high per cycle.
- Read-after-write across consecutive ops needs no stall: the write commits before the next FETCH completes.

Optional Feature:
- Macro KF_BANK_SEQ_TIMEOUT_EN adds parameter TIMEOUT (default 255) and a counter.
- The counter clears on entry to ISSUE/WAIT and increments each cycle in ISSUE or WAIT.
- Reaching TIMEOUT: err=1, alu_req_valid drops, -> DONE. No bank write occurs.
- Without the macro: the sequencer waits indefinitely and no counter logic is present.

Decomposition:
- Shared package kf_pkg: opcode constants (OP_ADD..OP_HALT), micro-op field widths/offsets, state encoding.
- One natural sub-module: kf_prog_table, a PROG_DEPTH x (3+3*ADDRW) flop table, sync write, registered read into ir, no reset.

Test Plan:
- Program [MUL 5<-1,2; HALT], db[1]=3, db[2]=4, ALU ready immediately, result after 2 cycles:
  - -> one db_we with waddr=5, wdata=12; then done pulse; busy low; err=0.
- Program [MOVQ src 7; MOVD src 8; HALT], db[7]=0x000100, db[8]=0x000200:
  - -> rq_we with rq_d=0x000100, then rd_we with rd_d=0x000200, 4 cycles apart; done.
- ALU holds ready=0 for 6 cycles during ADD:
  - -> alu_req_valid and raddr_a/raddr_b stable all 6 cycles; exactly one handshake.
- Program with dst=45:
  - -> no db_we; err=1; done pulse.
- Table filled with COPY ops, no HALT:
  - -> 32 copies execute, then err=1, done.
- Assert rst_n low while in WAIT:
  - -> outputs 0 asynchronously; a later alu_rsp_valid causes no write.
- With KF_BANK_SEQ_TIMEOUT_EN, TIMEOUT=10, ALU never responds:
  - -> err=1 and done within 10 cycles of the handshake.
